// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue:
// default geometry and request FSM encodings.
package inst_fetch_queue_pkg;

    localparam int unsigned IFQ_WORD_SIZE = 16;
    localparam int unsigned IFQ_DEPTH     = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Small FIFO of {pc, instruction} pairs with flush;
// pointers carry an extra MSB to tell full from empty.
module inst_fetch_queue_fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset_N,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop & ~empty;
    // A push into a full queue is fine when the head leaves this cycle.
    assign do_push = push & (~full | do_pop);

    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the PC, issues reads on memory port 1
// and queues {pc, instruction} pairs for decode.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned          WORD_SIZE = IFQ_WORD_SIZE,
    parameter int unsigned          DEPTH     = IFQ_DEPTH,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    output logic                 readM1,
    output logic [WORD_SIZE-1:0] address1,
    input  logic [WORD_SIZE-1:0] data1,
    input  logic                 mem_ready,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 halt,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [WORD_SIZE-1:0] if_inst,
    output logic [WORD_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] num_fetched,
    output logic                 is_halted
);

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [WORD_SIZE-1:0]   fetch_pc;
    logic                   halt_q;
    logic                   q_full;
    logic                   q_empty;
    logic                   push;
    logic                   pop;
    logic                   issue;
    logic [2*WORD_SIZE-1:0] head;

    assign readM1   = (state == ST_WAIT);
    assign address1 = fetch_pc;

    assign issue = ~q_full & ~halt_q & ~halt & ~redirect;
    // A response arriving with a redirect belongs to the old path.
    assign push  = readM1 & mem_ready & ~redirect;
    assign pop   = if_valid & if_ready;

    assign if_valid  = ~q_empty;
    assign if_pc     = head[2*WORD_SIZE-1:WORD_SIZE];
    assign if_inst   = head[WORD_SIZE-1:0];
    assign is_halted = halt_q & (state == ST_IDLE) & q_empty;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (issue) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (mem_ready)     state_nxt = ST_IDLE;
                else if (redirect) state_nxt = ST_DROP;
            end
            ST_DROP: if (mem_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state       <= ST_IDLE;
            fetch_pc    <= RESET_PC;
            halt_q      <= 1'b0;
            num_fetched <= '0;
        end else begin
            state  <= state_nxt;
            halt_q <= halt_q | halt;
            if (redirect)  fetch_pc <= redirect_pc;
            else if (push) fetch_pc <= fetch_pc + 1'b1;
            if (pop) num_fetched <= num_fetched + 1'b1;
        end
    end

    inst_fetch_queue_fetch_fifo #(
        .WIDTH (2*WORD_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .push      (push),
        .push_data ({fetch_pc, data1}),
        .pop       (pop),
        .flush     (redirect),
        .head_data (head),
        .full      (q_full),
        .empty     (q_empty)
    );

endmodule
